// File: rtl/cpu_lsu.sv
// Load/store unit: turns execute-stage load/store commands into single
// dmem transactions with byte enables, store replication, load extension,
// alignment checking and an optional ack timeout.
//
// Handshake: dmem_req_o rises on the first REQ cycle and stays high, with every
// dmem_* output frozen, until dmem_ack_i is sampled high on a rising edge. The
// transfer completes on that edge. dmem_ack_i is ignored in any other cycle.
//
// state_o exposes the FSM state for debug: 0=IDLE, 1=REQ, 2=DONE.
module cpu_lsu #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [1:0]  cmd_i,
  input  logic [2:0]  sx_i,
  input  logic [1:0]  st_size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_vld_o,
  output logic        err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter only has to reach TIMEOUT_CYC-1; the timeout fires on that cycle.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              ld_q;
  logic              sgn_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;

  logic              mem_op;
  logic              is_load;
  logic [1:0]        size_c;
  logic              legal_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic              timeout_hit;
  logic [31:0]       shifted;
  logic [31:0]       ext_c;

  assign mem_op      = valid_i && cmd_i[1];
  assign is_load     = cmd_i[0];
  assign size_c      = is_load ? sx_i[1:0] : st_size_i;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);
  assign state_o     = state_q;

  // Decode legality, byte enables and replicated store data of the presented access.
  always_comb begin
    legal_c = 1'b1;
    be_c    = 4'b1111;
    wdata_c = wdata_i;
    unique case (size_c)
      2'b00: begin
        legal_c = (addr_i[1:0] == 2'b00);
        be_c    = 4'b1111;
        wdata_c = wdata_i;
      end
      2'b01: begin
        legal_c = !addr_i[0];
        be_c    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        be_c    = 4'b0001 << addr_i[1:0];
        wdata_c = {4{wdata_i[7:0]}};
      end
      default: begin
        legal_c = 1'b0;
        be_c    = 4'b0000;
        wdata_c = wdata_i;
      end
    endcase
  end

  // Align returned read data to bit 0 and extend it to 32 bits.
  always_comb begin
    shifted = dmem_rdata_i >> {off_q, 3'b000};
    ext_c   = shifted;
    unique case (size_q)
      2'b01:   ext_c = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
      2'b10:   ext_c = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
      default: ext_c = shifted;
    endcase
  end

  // Next-state logic and the combinational pipeline hold.
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall_o = 1'b1;
          state_d = legal_c ? REQ : DONE;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (dmem_ack_i || timeout_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Bus registers, captured access attributes, timeout counter and result strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      rdata_o      <= '0;
      rdata_vld_o  <= 1'b0;
      err_o        <= 1'b0;
      cnt_q        <= '0;
      ld_q         <= 1'b0;
      sgn_q        <= 1'b0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
    end else begin
      rdata_vld_o <= 1'b0;
      err_o       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mem_op) begin
            if (legal_c) begin
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= !is_load;
              dmem_addr_o  <= {addr_i[31:2], 2'b00};
              dmem_be_o    <= be_c;
              dmem_wdata_o <= wdata_c;
              ld_q         <= is_load;
              sgn_q        <= sx_i[2];
              off_q        <= addr_i[1:0];
              size_q       <= size_c;
              cnt_q        <= '0;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        REQ: begin
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            if (ld_q) begin
              rdata_o     <= ext_c;
              rdata_vld_o <= 1'b1;
            end
          end else if (timeout_hit) begin
            dmem_req_o <= 1'b0;
            err_o      <= 1'b1;
          end else if (TIMEOUT_CYC != 0) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_lsu.sv
// Bench for cpu_lsu: per-cycle expected records from a transaction-level model.
module tb_cpu_lsu;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic [1:0]  cmd_i;
  logic [2:0]  sx_i;
  logic [1:0]  st_size_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_vld_o;
  logic        err_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic [1:0]  state_o;

  cpu_lsu #(.TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .cmd_i        (cmd_i),
    .sx_i         (sx_i),
    .st_size_i    (st_size_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .stall_o      (stall_o),
    .rdata_o      (rdata_o),
    .rdata_vld_o  (rdata_vld_o),
    .err_o        (err_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .state_o      (state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        req;
    logic        err;
    logic        vld;
    logic        chk_bus;
    logic        we;
    logic [1:0]  state;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cmp_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] last_rdata = '0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_be = '0;
  logic        cap_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] off,
                                           input logic [1:0] size, input logic sgn);
    logic [31:0] s;
    logic [31:0] v;
    s = d >> (8 * off);
    if (size == 2'd1) begin
      v = s % 32'd65536;
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end else if (size == 2'd2) begin
      v = s % 32'd256;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else begin
      v = s;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'd0) return 4'hF;
    if (size == 2'd1) return (a % 4 >= 2) ? 4'hC : 4'h3;
    return 4'(1 << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'd0) return w;
    if (size == 2'd1) return (w % 32'd65536) * 32'd65537;
    return (w % 32'd256) * 32'h0101_0101;
  endfunction

  function automatic exp_t mk(input logic stall, input logic req, input logic err,
                              input logic vld, input logic [1:0] st);
    exp_t e;
    e = '0;
    e.stall = stall;
    e.req   = req;
    e.err   = err;
    e.vld   = vld;
    e.state = st;
    e.rdata = last_rdata;
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      chk("stall", 32'(stall_o), 32'(cmp_e.stall));
      chk("dmem_req", 32'(dmem_req_o), 32'(cmp_e.req));
      chk("err", 32'(err_o), 32'(cmp_e.err));
      chk("rdata_vld", 32'(rdata_vld_o), 32'(cmp_e.vld));
      chk("rdata", rdata_o, cmp_e.rdata);
      chk("state", 32'(state_o), 32'(cmp_e.state));
      if (cmp_e.chk_bus) begin
        chk("dmem_addr", dmem_addr_o, cmp_e.addr);
        chk("dmem_be", 32'(dmem_be_o), 32'(cmp_e.be));
        chk("dmem_wdata", dmem_wdata_o, cmp_e.wdata);
        chk("dmem_we", 32'(dmem_we_o), 32'(cmp_e.we));
        if (cmp_e.req) begin
          cap_addr  = dmem_addr_o;
          cap_be    = dmem_be_o;
          cap_wdata = dmem_wdata_o;
          cap_we    = dmem_we_o;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    dmem_ack_i   = 1'($urandom_range(0, 1));
    dmem_rdata_i = $urandom;
  endtask

  // A cycle with no memory instruction presented (possibly a non-memory one).
  task automatic idle_cycle();
    next_cycle();
    valid_i   = 1'($urandom_range(0, 1));
    cmd_i     = 2'($urandom_range(0, 1));
    sx_i      = 3'($urandom);
    st_size_i = 2'($urandom);
    addr_i    = $urandom;
    wdata_i   = $urandom;
    noise();
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
  endtask

  // One load/store; ack_cyc is the 1-based REQ cycle carrying the ack (0 = never).
  task automatic do_op(input logic [1:0] cmd, input logic [2:0] sx, input logic [1:0] st,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int ack_cyc, input logic [31:0] mem_rd);
    logic       is_load;
    logic [1:0] size;
    logic       legal;
    logic       fin;
    logic       ok;
    logic       to_err;
    exp_t       bus;
    exp_t       e;
    is_load = (cmd == 2'b11);
    size    = is_load ? sx[1:0] : st;
    legal   = (size != 2'd3) && !(size == 2'd1 && addr % 2 != 0) &&
              !(size == 2'd0 && addr % 4 != 0);
    next_cycle();
    valid_i = 1'b1; cmd_i = cmd; sx_i = sx; st_size_i = st; addr_i = addr; wdata_i = wdata;
    noise();
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
    if (!legal) begin
      next_cycle();
      noise();
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd2));
      return;
    end
    bus         = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    bus.chk_bus = 1'b1;
    bus.we      = !is_load;
    bus.addr    = addr - (addr % 4);
    bus.be      = model_be(size, addr);
    bus.wdata   = model_wdata(size, wdata);
    fin = 1'b0; ok = 1'b0; to_err = 1'b0;
    for (int k = 1; k <= TO + 8 && !fin; k++) begin
      next_cycle();
      dmem_ack_i   = (k == ack_cyc);
      dmem_rdata_i = (k == ack_cyc) ? mem_rd : $urandom;
      exp_q.push_back(bus);
      if (k == ack_cyc) begin
        ok = 1'b1; fin = 1'b1;
      end else if (k == TO) begin
        to_err = 1'b1; fin = 1'b1;
      end
    end
    next_cycle();
    noise();
    if (ok && is_load) last_rdata = load_ext(mem_rd, 2'(addr % 4), size, sx[2]);
    e = mk(1'b0, 1'b0, to_err, ok && is_load, 2'd2);
    exp_q.push_back(e);
  endtask

  // Reset asserted in the 2nd REQ cycle of a load, ack arriving afterwards.
  task automatic reset_in_req();
    exp_t e;
    next_cycle();
    valid_i = 1'b1; cmd_i = 2'b11; sx_i = 3'b000; addr_i = 32'h0000_0400;
    dmem_ack_i = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      dmem_ack_i = 1'b0;
      if (k == 2) rst_n = 1'b0;
      e = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
      e.chk_bus = 1'b1; e.addr = 32'h0000_0400; e.be = 4'hF;
      e.wdata = model_wdata(2'd0, wdata_i);
      exp_q.push_back(e);
    end
    last_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      rst_n = 1'b1; valid_i = 1'b0;
      dmem_ack_i = 1'b1; dmem_rdata_i = $urandom;
      e = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      e.chk_bus = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    exp_t e;
    rst_n = 1'b0; valid_i = 1'b0; cmd_i = 2'b00; sx_i = '0; st_size_i = '0;
    addr_i = '0; wdata_i = '0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;

    // Reset: all outputs zero
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 3) rst_n = 1'b1;
      e = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      e.chk_bus = 1'b1;
      exp_q.push_back(e);
    end

    // Hand-computed values pinning the model
    chk("pin_ext_sbyte", load_ext(32'h80FF_1234, 2'd3, 2'd2, 1'b1), 32'hFFFF_FF80);
    chk("pin_ext_uhalf", load_ext(32'h8001_0000, 2'd2, 2'd1, 1'b0), 32'h0000_8001);
    chk("pin_st_half", model_wdata(2'd1, 32'h0000_ABCD), 32'hABCD_ABCD);
    chk("pin_be_half", 32'(model_be(2'd1, 32'h202)), 32'h0000_000C);

    // Signed byte load at 0x103, ack on first REQ cycle
    do_op(2'b11, 3'b110, 2'b00, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234);
    chk("d_lb_rdata", rdata_o, 32'hFFFF_FF80);
    chk("d_lb_be", 32'(cap_be), 32'h0000_0008);

    // Half store at 0x202
    do_op(2'b10, 3'b000, 2'b01, 32'h0000_0202, 32'h0000_ABCD, 2, 32'h0);
    chk("d_sh_addr", cap_addr, 32'h0000_0200);
    chk("d_sh_be", 32'(cap_be), 32'h0000_000C);
    chk("d_sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("d_sh_we", 32'(cap_we), 32'h1);

    // Misaligned word load
    do_op(2'b11, 3'b000, 2'b00, 32'h0000_0101, 32'h0, 1, 32'h0);
    chk("d_lw_misalign_err", 32'(err_o), 32'h1);

    // Timeout, then ack exactly on the timeout cycle, then ack too late
    do_op(2'b11, 3'b000, 2'b00, 32'h0000_0300, 32'h0, 0, 32'h0);
    chk("d_timeout_err", 32'(err_o), 32'h1);
    do_op(2'b11, 3'b000, 2'b00, 32'h0000_0300, 32'h0, TO, 32'h1234_5678);
    chk("d_ack_wins_err", 32'(err_o), 32'h0);
    do_op(2'b10, 3'b000, 2'b00, 32'h0000_0300, 32'h5555_AAAA, TO + 1, 32'h0);

    // Reset during REQ
    reset_in_req();

    // Unsigned half load at 0x2
    do_op(2'b11, 3'b001, 2'b00, 32'h0000_0002, 32'h0, 1, 32'h8001_0000);
    chk("d_lhu_rdata", rdata_o, 32'h0000_8001);

    // Illegal store size
    do_op(2'b10, 3'b000, 2'b11, 32'h0000_0500, 32'hDEAD_BEEF, 1, 32'h0);

    // Random traffic
    for (int n = 0; n < 120; n++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      do_op({1'b1, 1'($urandom_range(0, 1))}, 3'($urandom), 2'($urandom),
            $urandom, $urandom, int'($urandom_range(0, 6)), $urandom);
    end
    idle_cycle();

    @(negedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_lsu.md
CPU_LSU -- requirements
Module: cpu_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: maximum REQ-state cycles without dmem_ack_i; 0 disables the timeout.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port valid_i  in  1  execute-stage instruction valid.
REQ-005 SHALL have port cmd_i  in  2  11=load, 10=store, 01/00=non-memory (ignored).
REQ-006 SHALL have port sx_i  in  3  load control {sign, size}: sign 1=signed, 0=unsigned; size 00=word, 01=half, 10=byte, 11=illegal.
REQ-007 SHALL have port st_size_i  in  2  store size, same encoding as sx_i[1:0].
REQ-008 SHALL have port addr_i  in  32  byte address from ALU.
REQ-009 SHALL have port wdata_i  in  32  store data, right-justified.
REQ-010 SHALL have port stall_o  out  1  pipeline hold.
REQ-011 SHALL have port rdata_o  out  32  extended load result.
REQ-012 SHALL have port rdata_vld_o  out  1  one-cycle load-result strobe.
REQ-013 SHALL have port err_o  out  1  one-cycle misalign, illegal-size or timeout strobe.
REQ-014 SHALL have ports dmem_req_o out 1, dmem_we_o out 1, dmem_addr_o out 32 (bits[1:0]=00), dmem_be_o out 4, dmem_wdata_o out 32, dmem_ack_i in 1, dmem_rdata_i in 32.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, DONE.
REQ-016 IDLE, valid_i=1 and cmd_i in {11,10}: stall_o=1 combinationally; legal access -> REQ; illegal -> DONE with err_o=1 in DONE and no dmem request.
REQ-017 Legality: size 11 illegal; half requires addr[0]=0; word requires addr[1:0]=00.
REQ-018 On IDLE->REQ, SHALL register dmem_addr_o={addr[31:2],2'b00}, dmem_we_o (1 for store), dmem_be_o and dmem_wdata_o, and assert dmem_req_o from the first REQ cycle.
REQ-019 Byte enables: word 1111; half 0011 for addr[1]=0, 1100 for addr[1]=1; byte 0001<<addr[1:0].
REQ-020 Store data: word as is; half replicated {w[15:0],w[15:0]}; byte replicated 4x w[7:0].
REQ-021 REQ: dmem_req_o and all dmem_* outputs held stable until dmem_ack_i sampled 1; stall_o=1 throughout.
REQ-022 Ack in REQ: dmem_req_o deasserts next cycle; state -> DONE; a load captures dmem_rdata_i shifted right by addr[1:0]*8, then sign- or zero-extended to 32 bits per sx_i (word ignores sign), into rdata_o.
REQ-023 Timeout counter: cleared on REQ entry, +1 per REQ cycle without ack; reaching TIMEOUT_CYC -> DONE with err_o=1 and rdata_vld_o=0.
REQ-024 Ack in the same cycle the timeout is reached: ack wins, no err_o.
REQ-025 DONE lasts exactly 1 cycle: stall_o=0, rdata_vld_o=1 for a successful load only, then -> IDLE; valid_i/cmd_i are ignored in DONE (same instruction still presented).
REQ-026 rdata_o holds its last value until the next load capture.
REQ-027 dmem_ack_i outside REQ SHALL be ignored.
REQ-028 Load-to-use latency: minimum 3 cycles from IDLE acceptance to rdata_vld_o (IDLE, REQ with ack, DONE).

Reset
REQ-029 rst_n=0 at an edge: state=IDLE, counter=0, all outputs 0 (rdata_o=0, dmem_be_o=0000) the following cycle.
REQ-030 Reset during REQ SHALL drop dmem_req_o at that edge; a late ack SHALL be ignored.

Verification
REQ-031 Load byte signed, addr=0x103, dmem_rdata_i=0x80FF_1234, ack on 1st REQ cycle -> dmem_be_o=1000, rdata_o=0xFFFF_FF80, rdata_vld_o pulse, stall_o high for 2 cycles.
REQ-032 Store half, addr=0x202, wdata=0x0000_ABCD -> dmem_addr_o=0x200, dmem_be_o=1100, dmem_wdata_o=0xABCD_ABCD, dmem_we_o=1.
REQ-033 Load word, addr=0x101 -> no dmem_req_o, err_o pulse in 2nd cycle, stall_o high 1 cycle.
REQ-034 TIMEOUT_CYC=4, ack never -> 4 REQ cycles, err_o pulse, no rdata_vld_o; repeat with ack on the 4th REQ cycle -> no err_o.
REQ-035 rst_n=0 during 2nd REQ cycle, then ack -> dmem_req_o=0 next cycle, no rdata_vld_o, state IDLE.
REQ-036 Load half unsigned, addr=0x2, dmem_rdata_i=0x8001_0000 -> rdata_o=0x0000_8001.
